// File: rtl/apb_mem_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_slave_if
//  Brief    : APB4 bus bundle between a master and apb_mem_slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_mem_slave_if #(
   parameter int DATA_W = 32
);
   logic [31:0]         paddr;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [DATA_W/8-1:0] pstrb;
   logic [DATA_W-1:0]   prdata;
   logic                pready;
   logic                pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_slave
//  Brief    : Parametrised APB4 memory slave with byte strobes, configurable
//             wait states and pslverr on out-of-range/misaligned accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_slave #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              pclk,
   input  logic              presetn,
   apb_mem_slave_if.slave    bus
);
   localparam int BW  = DATA_W / 8;
   localparam int LB  = $clog2(BW);
   localparam int AW  = $clog2(DEPTH);
   localparam int LIM = AW + LB;
   localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic              r_err;
   logic [AW-1:0]     r_idx;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_prdata;
   logic              r_pready;
   logic              r_pslverr;

   logic              w_mis;
   logic              w_oor;
   logic              w_err;
   logic [AW-1:0]     w_idx;

   // Byte-wide buses have no alignment constraint.
   generate
      if (LB == 0) begin : g_no_align
         assign w_mis = 1'b0;
      end else begin : g_align
         assign w_mis = |bus.paddr[LB-1:0];
      end
   endgenerate

   // Any address bit above the memory window means out of range.
   generate
      if (LIM >= 32) begin : g_no_range
         assign w_oor = 1'b0;
      end else begin : g_range
         assign w_oor = |bus.paddr[31:LIM];
      end
   endgenerate

   assign w_err = w_mis | w_oor;
   assign w_idx = bus.paddr[LB +: AW];

   // Transfer FSM, registered response outputs and the memory array.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_idx     <= '0;
         r_prdata  <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Only a genuine setup phase (penable low) starts a transfer.
               if (bus.psel && !bus.penable) begin
                  r_write <= bus.pwrite;
                  r_err   <= w_err;
                  r_idx   <= w_idx;
                  r_cnt   <= C_WAIT;
                  if (WAIT_CYCLES == 0) begin
                     r_state   <= ST_RESP;
                     r_pready  <= 1'b1;
                     r_pslverr <= w_err;
                     r_prdata  <= (!bus.pwrite && !w_err) ? r_mem[w_idx] : '0;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // Master dropping psel abandons the transfer silently.
               if (!bus.psel) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd1) begin
                  r_state   <= ST_RESP;
                  r_pready  <= 1'b1;
                  r_pslverr <= r_err;
                  r_prdata  <= (!r_write && !r_err) ? r_mem[r_idx] : '0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state   <= ST_IDLE;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
               r_prdata  <= '0;
               // Write data and strobes are taken from the bus in the response cycle.
               if (r_write && !r_err) begin
                  for (int i = 0; i < BW; i++) begin
                     if (bus.pstrb[i]) begin
                        r_mem[r_idx][i*8 +: 8] <= bus.pwdata[i*8 +: 8];
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.prdata  = r_prdata;
   assign bus.pready  = r_pready;
   assign bus.pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mem_slave
//  Brief    : Self-checking bench for apb_mem_slave (2-wait and 0-wait builds).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        tgt = 1'b0;       // 0: 2-wait-state slave, 1: zero-wait slave
   logic [31:0] paddr = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [31:0] w_prdata;
   logic        w_pready;
   logic        w_pslverr;

   int total = 0;
   int bad = 0;

   // Byte-level reference memory for each slave.
   logic [7:0] mdl [2][64];

   always #5 pclk = ~pclk;

   apb_mem_slave_if #(.DATA_W(32)) bus_a ();
   apb_mem_slave_if #(.DATA_W(32)) bus_z ();

   assign bus_a.paddr   = paddr;
   assign bus_a.psel    = psel && !tgt;
   assign bus_a.penable = penable;
   assign bus_a.pwrite  = pwrite;
   assign bus_a.pwdata  = pwdata;
   assign bus_a.pstrb   = pstrb;
   assign bus_z.paddr   = paddr;
   assign bus_z.psel    = psel && tgt;
   assign bus_z.penable = penable;
   assign bus_z.pwrite  = pwrite;
   assign bus_z.pwdata  = pwdata;
   assign bus_z.pstrb   = pstrb;

   assign w_prdata  = tgt ? bus_z.prdata  : bus_a.prdata;
   assign w_pready  = tgt ? bus_z.pready  : bus_a.pready;
   assign w_pslverr = tgt ? bus_z.pslverr : bus_a.pslverr;

   apb_mem_slave #(.DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) u_dut_a (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus_a.slave)
   );

   apb_mem_slave #(.DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_dut_z (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus_z.slave)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit mdl_err(input logic [31:0] a);
      return (a >= 32'd64) || ((a % 4) != 0);
   endfunction

   function automatic logic [31:0] mdl_rd(input bit t, input logic [31:0] a);
      int b = int'(a[5:0]);
      return {mdl[t][b+3], mdl[t][b+2], mdl[t][b+1], mdl[t][b]};
   endfunction

   task automatic mdl_wr(input bit t, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
      int b = int'(a[5:0]);
      for (int i = 0; i < 4; i++) begin
         if (s[i]) mdl[t][b+i] = d[8*i +: 8];
      end
   endtask

   task automatic mdl_clear();
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 64; i++) mdl[t][i] = 8'h00;
      end
   endtask

   // One complete APB transfer; lat = access cycle in which pready was seen (0 = timeout).
   task automatic xfer(input bit t, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, output logic [31:0] rd, output bit er,
                       output int lat);
      @(negedge pclk);
      tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = a; pwdata = wd; pstrb = sb;
      @(posedge pclk);
      @(negedge pclk);
      penable = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         if (w_pready) begin
            lat = k;
            break;
         end
         @(posedge pclk);
         @(negedge pclk);
      end
      rd = w_prdata;
      er = w_pslverr;
      if (lat == 0) begin
         psel = 1'b0;
         penable = 1'b0;
      end
      @(posedge pclk);
   endtask

   task automatic bus_idle();
      @(negedge pclk);
      psel = 1'b0;
      penable = 1'b0;
   endtask

   // Transfer plus checks of latency, error and read data against the model.
   task automatic xfer_chk(input string nm, input bit t, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] sb);
      logic [31:0] rd;
      logic [31:0] exp_rd;
      bit er;
      bit exp_er;
      int lat;
      exp_er = mdl_err(a);
      exp_rd = (!wr && !exp_er) ? mdl_rd(t, a) : 32'h0;
      xfer(t, wr, a, wd, sb, rd, er, lat);
      chk({nm, "_lat"}, lat, t ? 1 : 3);
      chk({nm, "_err"}, er, exp_er);
      if (!wr || exp_er) chk({nm, "_rdata"}, rd, exp_rd);
      if (wr && !exp_er) mdl_wr(t, a, wd, sb);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      bit er;
      bit seen;
      int lat;
      int r;

      tbl[0] = '{1'b1, 32'h3C, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      tbl[1] = '{1'b0, 32'h3C, 32'h0,       4'h0, 32'hDEADBEEF, 1'b0};
      tbl[2] = '{1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0,        1'b0};
      tbl[3] = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
      tbl[4] = '{1'b0, 32'h08, 32'h0,       4'hF, 32'h11BB33DD, 1'b0};
      tbl[5] = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1};
      tbl[6] = '{1'b0, 32'h02, 32'h0,       4'h0, 32'h0,        1'b1};
      tbl[7] = '{1'b1, 32'h06, 32'h87654321, 4'hF, 32'h0,        1'b1};
      tbl[8] = '{1'b1, 32'hFFFFFFFC, 32'h5A5A5A5A, 4'hF, 32'h0,  1'b1};
      tbl[9] = '{1'b0, 32'h3C, 32'h0,       4'hF, 32'hDEADBEEF, 1'b0};

      mdl_clear();

      // Reset state, during and just after reset.
      repeat (3) @(negedge pclk);
      chk("reset_outputs", {w_pready, w_pslverr, w_prdata}, 34'h0);
      presetn = 1'b1;
      @(negedge pclk);
      chk("post_reset_outputs", {w_pready, w_pslverr, w_prdata}, 34'h0);

      // Directed vectors on the 2-wait-state slave.
      for (int i = 0; i < 10; i++) begin
         xfer(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, er, lat);
         chk($sformatf("vec%0d_lat", i), lat, 3);
         chk($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
         if (!tbl[i].wr || tbl[i].exp_err) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         if (tbl[i].wr && !tbl[i].exp_err) mdl_wr(1'b0, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      end

      // Erroring writes must have left every word untouched.
      for (int w = 0; w < 16; w++) begin
         xfer_chk($sformatf("readback%0d", w), 1'b0, 1'b0, 32'(w * 4), 32'h0, 4'h0);
      end
      bus_idle();

      // Abort: psel dropped in the second wait cycle of a write to 0x4.
      @(negedge pclk);
      tgt = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h4; pwdata = 32'h99999999; pstrb = 4'hF;
      @(posedge pclk);
      @(negedge pclk);
      penable = 1'b1;
      seen = w_pready;
      @(posedge pclk);
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (w_pready) seen = 1'b1;
         @(negedge pclk);
      end
      chk("abort_no_pready", seen, 1'b0);
      xfer_chk("abort_word", 1'b0, 1'b0, 32'h4, 32'h0, 4'h0);
      bus_idle();

      // Spurious enable with no setup phase.
      @(negedge pclk);
      tgt = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge pclk);
         if (w_pready) seen = 1'b1;
      end
      chk("spurious_enable", seen, 1'b0);
      bus_idle();

      // Randomised traffic against the byte-level model.
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)      a = 32'($urandom_range(0, 15) * 4);
         else if (r < 9) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else            a = 32'h40 + 32'($urandom_range(0, 255));
         xfer_chk($sformatf("rnd%0d", n), 1'b0, 1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(0, 15)));
      end
      xfer_chk("rnd_final_3c", 1'b0, 1'b0, 32'h3C, 32'h0, 4'h0);

      // Asynchronous reset while the response is on the bus.
      @(negedge pclk);
      tgt = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h20; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
      @(posedge pclk);
      @(negedge pclk);
      penable = 1'b1;
      repeat (2) begin
         @(posedge pclk);
         @(negedge pclk);
      end
      chk("resp_before_reset", w_pready, 1'b1);
      presetn = 1'b0;
      #1;
      chk("async_reset_resp", {w_pready, w_pslverr, w_prdata}, 34'h0);
      @(negedge pclk);
      presetn = 1'b1; psel = 1'b0; penable = 1'b0;
      mdl_clear();
      xfer_chk("after_resp_reset_20", 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
      bus_idle();

      // Asynchronous reset in the middle of the wait states.
      @(negedge pclk);
      tgt = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      @(posedge pclk);
      @(negedge pclk);
      penable = 1'b1;
      presetn = 1'b0;
      #1;
      chk("async_reset_wait", {w_pready, w_pslverr, w_prdata}, 34'h0);
      @(negedge pclk);
      presetn = 1'b1; psel = 1'b0; penable = 1'b0;
      xfer_chk("after_wait_reset_0", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      xfer_chk("after_wait_reset_10", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);

      // Back-to-back zero-wait transfers with no idle cycles.
      xfer_chk("b2b_wr0", 1'b1, 1'b1, 32'h0, 32'h1, 4'hF);
      xfer_chk("b2b_wr4", 1'b1, 1'b1, 32'h4, 32'h2, 4'hF);
      xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
      chk("b2b_rd0_lat", lat, 1);
      chk("b2b_rd0_err", er, 1'b0);
      chk("b2b_rd0_rdata", rd, 32'h1);
      xfer_chk("b2b_rd4", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
      xfer_chk("zw_err_rd", 1'b1, 1'b0, 32'h41, 32'h0, 4'h0);
      bus_idle();

      repeat (2) @(negedge pclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-mapped slave: the next generation of our fixed 8-bit, 16-entry APB slave. Data width, depth and wait-state count are configurable, and byte strobes are supported. Out-of-range and misaligned accesses complete with `pslverr`. All outputs are registered. It sits on the peripheral APB bus behind the bridge as a scratch/register bank and is the DUT for the APB UVM environment.

## Interface
- `DATA_W`, 32, data width in bits; one of 8/16/32/64.
- `DEPTH`, 16, number of `DATA_W` words; power of two, ≥2.
- `WAIT_CYCLES`, 0, extra access cycles before `pready`; range 0..15.
- `pclk`  in  1  bus clock; all state changes on the rising edge.
- `presetn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `paddr`  in  32  byte address.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `pwdata`  in  DATA_W  write data.
- `pstrb`  in  DATA_W/8  byte-lane write enables.
- `prdata`  out  DATA_W  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer complete.
- `pslverr`  out  1  error response; valid only while `pready`=1.

## Operation
- Terms:
  - BW = `DATA_W`/8.
  - Word index = `paddr` / BW.
  - Valid address range is 0 .. DEPTH·BW−1.
- Error condition, evaluated at the setup sample. Either of the following gives an error:
  - `paddr` ≥ DEPTH·BW;
  - `paddr` % BW ≠ 0 (misaligned).
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with `psel`=1 and `penable`=0 (setup), latch the direction and the error flag.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to RESP if `WAIT_CYCLES`=0, otherwise go to WAIT.
  - `penable`=1 without a preceding setup is ignored; the block stays in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - `psel`=0 in any WAIT cycle aborts the transfer: go to IDLE, no write, no `pready`.
- RESP (`pready`=1, exactly one cycle):
  - Read, no error: `prdata` = mem[index], registered on the edge entering RESP.
  - Error (read or write): `pslverr`=1, `prdata`=0.
  - Write, no error: on the edge leaving RESP, for each lane i with `pstrb`[i]=1, write mem[index] byte i ← `pwdata` byte i. Lanes with `pstrb`=0 are unchanged.
  - An erroring write never modifies memory.
  - A read ignores `pstrb`.
  - Always return to IDLE.
- Address and data are sampled at the setup edge. Write data and strobes are also taken from the bus during RESP; APB requires them stable.
- Back-to-back transfers: the master's next setup cycle immediately follows RESP, and IDLE samples it. There is no dead cycle beyond the APB protocol.
- Memory width: DEPTH × `DATA_W` flops. Reset clears memory to 0.

## Timing
- Reset (`presetn`=0, asynchronous):
  - State = IDLE.
  - `pready`=0, `pslverr`=0, `prdata`=0.
  - All memory words = 0.
  - These values hold until the first rising edge after deassertion.
- Reset during WAIT or RESP aborts the transfer with no memory update.
- Latency: `pready` rises in access cycle `WAIT_CYCLES`+1, where access cycle 1 is the cycle after setup.
  - A zero-wait transfer takes 2 cycles total.
  - A `WAIT_CYCLES`=2 transfer takes 4 cycles total.
- Outside RESP: `pready`=0, `pslverr`=0, `prdata`=0.
- A write's effect is visible to a read whose setup is sampled on or after the edge leaving the write's RESP.

## Test plan
- Reset: assert `presetn`=0 mid-WAIT → all outputs 0 immediately. After release, a read of 0x0 returns 0x00000000 and `pslverr`=0.
- Aligned write then read (DATA_W=32, DEPTH=16, WAIT_CYCLES=2):
  - Write 0xDEADBEEF to 0x3C with `pstrb`=0xF.
  - Read 0x3C → `pready` in access cycle 3, `prdata`=0xDEADBEEF, `pslverr`=0.
- Byte strobes:
  - Write 0xAABBCCDD to 0x8 with `pstrb`=0x5 over a word holding 0x11223344.
  - Read 0x8 → 0x11BB33DD.
- Errors:
  - Write to 0x40 → `pready` and `pslverr`=1 in the same cycle.
  - Read 0x2 (misaligned) → `pslverr`=1, `prdata`=0.
  - Memory is unchanged, confirmed by reading back all 16 words.
- Abort and spurious enable:
  - Drop `psel` during WAIT of a write to 0x4 → no `pready`, word unchanged.
  - `penable`=1 with no setup → no `pready`.
- Back-to-back zero-wait (WAIT_CYCLES=0):
  - Write 0x1 to 0x0, then write 0x2 to 0x4, then read 0x0 with no idle cycles between transfers.
  - Each transfer completes in 2 cycles; the read returns 0x00000001.
